pwm_compare: RTL and testbench

Downstream consumer of the 4-bit reloadable counter's count value. Compares the live count against a double-buffered compare threshold to produce a registered PWM output. Detects counter wrap (count at all-ones) and emits a wrap pulse and a saturating wrap tally. New thresholds arrive over a valid/ready handshake and take effect only at a wrap boundary, so no period is ever glitched.

---
 rtl/pwm_compare.sv | 62 ++++++
 tb/tb_pwm_compare.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_compare.sv
// PWM comparator with a double-buffered threshold applied only at counter wrap, plus a wrap pulse and a saturating wrap tally.
// Outputs lag count_i by one cycle. cmp_ready_o stays low while a threshold waits for the next wrap.
module pwm_compare #(
    parameter int CW  = 4,
    parameter int WCW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [CW-1:0]  count_i,
    input  logic           en_i,
    input  logic           cmp_valid_i,
    input  logic [CW-1:0]  cmp_i,
    output logic           cmp_ready_o,
    input  logic           clr_i,
    output logic           pwm_o,
    output logic           wrap_o,
    output logic [WCW-1:0] wrap_cnt_o
);

    logic [CW-1:0] active_cmp;
    logic [CW-1:0] pend_cmp;
    logic          pend_v;
    logic          wrap_evt;
    logic          accept;
    logic          tally_sat;

    assign wrap_evt    = (count_i == {CW{1'b1}});
    assign cmp_ready_o = ~pend_v;
    assign accept      = cmp_valid_i & ~pend_v;
    assign tally_sat   = (wrap_cnt_o == {WCW{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_cmp <= '0;
            pend_cmp   <= '0;
            pend_v     <= 1'b0;
            pwm_o      <= 1'b0;
            wrap_o     <= 1'b0;
            wrap_cnt_o <= '0;
        end else begin
            // Compare uses the threshold in force before this edge's shadow update.
            pwm_o  <= en_i & (count_i < active_cmp);
            wrap_o <= wrap_evt;

            if (clr_i) begin
                wrap_cnt_o <= '0;
            end else if (wrap_evt && !tally_sat) begin
                wrap_cnt_o <= wrap_cnt_o + WCW'(1);
            end

            // Shadow update and accept are exclusive: one needs a full slot, the other an empty one.
            if (wrap_evt && pend_v) begin
                active_cmp <= pend_cmp;
                pend_v     <= 1'b0;
            end else if (accept) begin
                pend_cmp <= cmp_i;
                pend_v   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_compare.sv
// Randomized and directed bench for pwm_compare against a threshold/slot reference model.
module tb_pwm_compare;

    localparam int CW   = 4;
    localparam int WCW  = 8;
    localparam int TOP  = (1 << CW) - 1;
    localparam int TMAX = (1 << WCW) - 1;

    logic           clk;
    logic           rst;
    logic [CW-1:0]  count_i;
    logic           en_i;
    logic           cmp_valid_i;
    logic [CW-1:0]  cmp_i;
    logic           cmp_ready_o;
    logic           clr_i;
    logic           pwm_o;
    logic           wrap_o;
    logic [WCW-1:0] wrap_cnt_o;

    pwm_compare #(.CW(CW), .WCW(WCW)) dut (
        .clk        (clk),
        .rst        (rst),
        .count_i    (count_i),
        .en_i       (en_i),
        .cmp_valid_i(cmp_valid_i),
        .cmp_i      (cmp_i),
        .cmp_ready_o(cmp_ready_o),
        .clr_i      (clr_i),
        .pwm_o      (pwm_o),
        .wrap_o     (wrap_o),
        .wrap_cnt_o (wrap_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference: threshold in force, waiting thresholds (at most one), wrap tally.
    int m_active;
    int m_slot[$];
    int m_tally;

    // Stimulus counter: 0 = reloading counter, 1 = random values, 2 = stuck at top.
    int mode;
    int reload;
    int highs;
    int wraps;
    bit last_acc;
    bit auto_prod;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_slot.delete();
        m_tally = 0;
    endtask

    task automatic step();
        bit is_wrap;
        bit acc;
        bit exp_pwm;
        int had;
        had     = m_slot.size();
        is_wrap = (int'(count_i) == TOP);
        acc     = cmp_valid_i && (had == 0);
        exp_pwm = en_i && (int'(count_i) < m_active);
        if (clr_i) m_tally = 0;
        else if (is_wrap) m_tally = (m_tally + 1 > TMAX) ? TMAX : m_tally + 1;
        if (is_wrap && had > 0) m_active = m_slot.pop_front();
        if (acc) m_slot.push_back(int'(cmp_i));
        @(posedge clk);
        #1;
        chk("pwm", int'(pwm_o), int'(exp_pwm));
        chk("wrap", int'(wrap_o), int'(is_wrap));
        chk("tally", int'(wrap_cnt_o), m_tally);
        chk("ready", int'(cmp_ready_o), int'(m_slot.size() == 0));
        last_acc = acc;
        highs += int'(pwm_o);
        wraps += int'(wrap_o);
        case (mode)
            0:       count_i = (int'(count_i) == TOP) ? CW'(reload) : count_i + CW'(1);
            1:       count_i = CW'($urandom_range(0, TOP));
            default: count_i = CW'(TOP);
        endcase
        if (auto_prod) begin
            if (acc) begin
                cmp_valid_i = $urandom_range(0, 1) != 0;
                cmp_i       = CW'($urandom_range(0, TOP));
            end else if (!cmp_valid_i && $urandom_range(0, 3) == 0) begin
                cmp_valid_i = 1'b1;
                cmp_i       = CW'($urandom_range(0, TOP));
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_cmp(input int v);
        int budget;
        cmp_valid_i = 1'b1;
        cmp_i       = CW'(v);
        last_acc    = 1'b0;
        budget      = 0;
        while (!last_acc && budget < 100) begin
            step();
            budget++;
        end
        if (!last_acc) chk("load_timeout", 0, 1);
        cmp_valid_i = 1'b0;
    endtask

    task automatic wait_count(input int v);
        int budget;
        budget = 0;
        while (int'(count_i) != v && budget < 64) begin
            step();
            budget++;
        end
        if (int'(count_i) != v) chk("count_timeout", int'(count_i), v);
    endtask

    initial begin
        rst = 1'b1;
        count_i = '0;
        en_i = 1'b1;
        cmp_valid_i = 1'b0;
        cmp_i = '0;
        clr_i = 1'b0;
        mode = 0;
        reload = 0;
        auto_prod = 1'b0;
        highs = 0;
        wraps = 0;
        last_acc = 1'b0;
        model_reset();
        #12;
        rst = 1'b0;
        chk("rst_pwm", int'(pwm_o), 0);
        chk("rst_wrap", int'(wrap_o), 0);
        chk("rst_tally", int'(wrap_cnt_o), 0);
        chk("rst_ready", int'(cmp_ready_o), 1);

        // Basic duty: threshold 4 on a full 16-count period.
        load_cmp(4);
        run(32);
        highs = 0; wraps = 0;
        run(16);
        chk("duty4_highs", highs, 4);
        chk("duty4_wraps", wraps, 1);

        // Backpressure: second offer waits while the first is pending.
        wait_count(2);
        load_cmp(3);
        chk("bp_ready_low", int'(cmp_ready_o), 0);
        load_cmp(9);
        run(40);
        highs = 0;
        run(16);
        chk("bp_duty9", highs, 9);

        // Accept on the wrap edge with an empty slot: value waits one more wrap.
        wait_count(TOP);
        load_cmp(2);
        chk("samewrap_pending", int'(cmp_ready_o), 0);
        highs = 0;
        run(16);
        chk("samewrap_old_duty", highs, 9);
        run(16);
        highs = 0;
        run(16);
        chk("samewrap_new_duty", highs, 2);

        // Short period C..F with threshold E.
        reload = 12;
        load_cmp(14);
        run(16);
        highs = 0; wraps = 0;
        run(8);
        chk("short_highs", highs, 4);
        chk("short_wraps", wraps, 2);

        // Enable low: output held off while the shadow update still happens.
        reload = 0;
        en_i = 1'b0;
        load_cmp(8);
        highs = 0;
        run(48);
        chk("en_off_highs", highs, 0);
        en_i = 1'b1;
        run(16);
        highs = 0;
        run(16);
        chk("en_on_duty8", highs, 8);

        // Zero threshold.
        load_cmp(0);
        run(32);
        highs = 0;
        run(16);
        chk("zero_highs", highs, 0);

        // Tally saturation, clear on a wrap edge, then counting resumes.
        mode = 2;
        count_i = CW'(TOP);
        run(300);
        chk("tally_sat", int'(wrap_cnt_o), TMAX);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        chk("tally_clr", int'(wrap_cnt_o), 0);
        step();
        chk("tally_after_clr", int'(wrap_cnt_o), 1);

        // Reset mid-run discards a pending threshold.
        mode = 0;
        count_i = '0;
        run(4);
        load_cmp(7);
        rst = 1'b1;
        #2;
        model_reset();
        chk("midrst_pwm", int'(pwm_o), 0);
        chk("midrst_wrap", int'(wrap_o), 0);
        chk("midrst_tally", int'(wrap_cnt_o), 0);
        chk("midrst_ready", int'(cmp_ready_o), 1);
        #2;
        rst = 1'b0;
        highs = 0;
        run(40);
        chk("midrst_lost", highs, 0);

        // Randomized traffic.
        auto_prod = 1'b1;
        for (int blk = 0; blk < 20; blk++) begin
            mode   = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 2)) : 0;
            reload = $urandom_range(0, TOP);
            for (int i = 0; i < 80; i++) begin
                en_i  = $urandom_range(0, 7) != 0;
                clr_i = $urandom_range(0, 31) == 0;
                step();
            end
        end
        clr_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
